ccff_bitstream_loader: RTL and testbench

- Drives the configuration-chain protocol from the host side.
- Accepts configuration words over a valid/ready stream, serializes them LSB-first onto `ccff_head`, and emits a shift enable that the top level uses to gate `prog_clk` into the fabric chain.
- Captures the bits leaving the chain on `ccff_tail`, re-packs them into words and returns them as a readback stream of the previous configuration.
- Sits between the host bitstream port and the head/tail of a tile's ccff chain.

---
 rtl/ccff_loader_pkg.sv | 21 ++
 rtl/ccff_word_packer.sv | 61 ++++++
 rtl/ccff_bitstream_loader.sv | 130 +++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared constants and sizing helpers for the configuration-chain loader.
package ccff_loader_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Bits needed to hold any value in 0..max_val (never less than 1).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned num_words(input int unsigned chain_len,
                                              input int unsigned word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/ccff_word_packer.sv
// Serial-to-parallel readback register with a one-word valid/ready/last holding stage.
module ccff_word_packer
    import ccff_loader_pkg::*;
#(
    parameter int unsigned WORD_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture,
    input  logic              tail,
    input  logic              final_bit,
    input  logic              ready,
    output logic              absorb_c,
    output logic [WORD_W-1:0] data,
    output logic              valid,
    output logic              last
);

    localparam int unsigned IDX_W = cnt_width(WORD_W - 1);

    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] acc_q;
    logic [WORD_W-1:0] word_c;
    logic              complete_c;

    // A completing bit can only be taken if the holding stage is free or draining now.
    always_comb begin
        complete_c   = (idx_q == IDX_W'(WORD_W - 1)) || final_bit;
        absorb_c     = !complete_c || !valid || ready;
        word_c       = acc_q;
        word_c[idx_q] = tail;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
            acc_q <= '0;
            data  <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
        end else begin
            if (valid && ready) begin
                valid <= 1'b0;
                last  <= 1'b0;
            end
            if (capture) begin
                if (complete_c) begin
                    data  <= word_c;
                    valid <= 1'b1;
                    last  <= final_bit;
                    acc_q <= '0;
                    idx_q <= '0;
                end else begin
                    acc_q <= word_c;
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Host-side configuration chain driver: serializes words onto ccff_head and repacks ccff_tail.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 20,
    parameter int unsigned WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W     = cnt_width(CHAIN_LEN);
    localparam int unsigned BIT_W     = cnt_width(WORD_W);
    localparam int unsigned NUM_WORDS = num_words(CHAIN_LEN, WORD_W);
    localparam int unsigned WRD_W     = cnt_width(NUM_WORDS);
    localparam int unsigned LAST_BITS = CHAIN_LEN - (NUM_WORDS - 1) * WORD_W;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [WRD_W-1:0]  words_q;
    logic [BIT_W-1:0]  bits_q;
    logic [WORD_W-1:0] word_q;
    logic              head_q;
    logic              shift_c;
    logic              load_c;
    logic              final_bit_c;
    logic              absorb_c;

    always_comb begin
        state_d     = state_q;
        shift_c     = 1'b0;
        s_ready     = 1'b0;
        final_bit_c = (cnt_q == CNT_W'(CHAIN_LEN - 1));
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                shift_c = (bits_q != '0) && absorb_c;
                // Refill when empty or when the last live bit leaves this cycle.
                s_ready = (words_q != WRD_W'(NUM_WORDS)) &&
                          ((bits_q == '0) || ((bits_q == BIT_W'(1)) && shift_c));
                if (shift_c && final_bit_c) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (m_valid && m_ready && m_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign load_c        = s_valid && s_ready;
    assign ccff_shift_en = shift_c;
    assign ccff_head     = shift_c ? word_q[0] : head_q;

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == ST_SHIFT) || (state_d == ST_DRAIN);
            done    <= (state_d == ST_DONE);
        end
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            cnt_q   <= '0;
            words_q <= '0;
            bits_q  <= '0;
            word_q  <= '0;
            head_q  <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && start) begin
                cnt_q   <= '0;
                words_q <= '0;
                bits_q  <= '0;
            end
            if (shift_c) begin
                cnt_q  <= cnt_q + CNT_W'(1);
                head_q <= word_q[0];
            end
            // The final word only carries the bits still missing from the chain.
            if (load_c) begin
                word_q  <= s_data;
                words_q <= words_q + WRD_W'(1);
                bits_q  <= (words_q == WRD_W'(NUM_WORDS - 1)) ? BIT_W'(LAST_BITS) : BIT_W'(WORD_W);
            end else if (shift_c) begin
                word_q <= word_q >> 1;
                bits_q <= bits_q - BIT_W'(1);
            end
            if (state_q == ST_DONE) head_q <= 1'b0;
        end
    end

    ccff_word_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk       (prog_clk),
        .reset     (prog_reset),
        .capture   (shift_c),
        .tail      (ccff_tail),
        .final_bit (final_bit_c),
        .ready     (m_ready),
        .absorb_c  (absorb_c),
        .data      (m_data),
        .valid     (m_valid),
        .last      (m_last)
    );

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: behavioural chain, per-cycle model compare, directed passes.
module tb_ccff_bitstream_loader;

    localparam int unsigned CHAIN_LEN = 20;
    localparam int unsigned WORD_W    = 8;
    localparam int          NW        = 3;

    logic                 prog_clk = 1'b0;
    logic                 prog_reset;
    logic                 start;
    logic [WORD_W-1:0]    s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic [WORD_W-1:0]    m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic                 m_last;
    logic                 ccff_head;
    logic                 ccff_tail;
    logic                 ccff_shift_en;
    logic                 busy;
    logic                 done;
    logic [CHAIN_LEN-1:0] chain = '0;

    ccff_bitstream_loader #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W)
    ) dut (
        .prog_clk      (prog_clk),
        .prog_reset    (prog_reset),
        .start         (start),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .ccff_head     (ccff_head),
        .ccff_tail     (ccff_tail),
        .ccff_shift_en (ccff_shift_en),
        .busy          (busy),
        .done          (done)
    );

    always #5 prog_clk = ~prog_clk;

    // Fabric chain: prog_clk gated by the shift enable, head at bit 0, tail at the top.
    always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
    assign ccff_tail = chain[CHAIN_LEN-1];

    int checks;
    int errors;
    bit         exp_head_q[$];
    logic [8:0] exp_rb_q[$];
    logic [7:0] words [NW];
    logic [7:0] got_rb [NW];
    logic [NW-1:0] got_last;
    logic [CHAIN_LEN-1:0] got_head;
    logic [CHAIN_LEN-1:0] exp_chain;
    logic [7:0] hold_data;
    int in_idx, gap_left, shift_cnt, consumed, done_cnt, rb_cnt, bp_shifts, bp_left;
    int cyc, first_acc_cyc, first_shift_cyc;
    bit gaps_on, bp_wait, spam, rst_mode, rst_sent, start_pend, rst_pend, hold_valid, last_busy;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".s_ready"},   32'(s_ready),       32'd0);
        chk({tag, ".m_valid"},   32'(m_valid),       32'd0);
        chk({tag, ".m_last"},    32'(m_last),        32'd0);
        chk({tag, ".m_data"},    32'(m_data),        32'd0);
        chk({tag, ".ccff_head"}, 32'(ccff_head),     32'd0);
        chk({tag, ".shift_en"},  32'(ccff_shift_en), 32'd0);
        chk({tag, ".busy"},      32'(busy),          32'd0);
        chk({tag, ".done"},      32'(done),          32'd0);
    endtask

    // Observe what the DUT will do at the coming edge and compare against the model.
    task automatic sample();
        logic [8:0] e;
        logic       completing;
        last_busy = busy;
        if (busy) start_pend = 1'b0;
        if (s_valid && s_ready) begin
            if (consumed == 0) first_acc_cyc = cyc;
            consumed++;
            in_idx++;
            if (gaps_on) gap_left = $urandom_range(0, 5);
        end
        if (ccff_shift_en) begin
            chk("busy_in_shift", 32'(busy), 32'd1);
            if (shift_cnt == 0) first_shift_cyc = cyc;
            completing = ((shift_cnt % WORD_W) == WORD_W - 1) || (shift_cnt == CHAIN_LEN - 1);
            if (m_valid && !m_ready) begin
                bp_shifts++;
                chk("no_readback_overflow", 32'(completing), 32'd0);
            end
            chk("head_expected", 32'(exp_head_q.size() > 0), 32'd1);
            if (exp_head_q.size() > 0) chk("ccff_head", 32'(ccff_head), 32'(exp_head_q.pop_front()));
            if (shift_cnt < CHAIN_LEN) got_head[5'(shift_cnt)] = ccff_head;
            shift_cnt++;
        end
        if (m_valid) begin
            if (m_ready) begin
                chk("readback_expected", 32'(exp_rb_q.size() > 0), 32'd1);
                if (exp_rb_q.size() > 0) begin
                    e = exp_rb_q.pop_front();
                    chk("m_data", 32'(m_data), 32'(e[7:0]));
                    chk("m_last", 32'(m_last), 32'(e[8]));
                end
                if (rb_cnt < NW) begin
                    got_rb[rb_cnt]   = m_data;
                    got_last[rb_cnt] = m_last;
                end
                rb_cnt++;
                hold_valid = 1'b0;
            end else begin
                if (hold_valid) chk("m_data_stable", 32'(m_data), 32'(hold_data));
                hold_valid = 1'b1;
                hold_data  = m_data;
                if (bp_wait) begin
                    bp_wait = 1'b0;
                    bp_left = 10;
                end
            end
        end else if (hold_valid) begin
            chk("m_valid_held", 32'(m_valid), 32'd1);
            hold_valid = 1'b0;
        end
        if (done) begin
            done_cnt++;
            chk("busy_at_done", 32'(busy), 32'd0);
        end
        if (rst_mode && !rst_sent && shift_cnt == 9) begin
            rst_pend = 1'b1;
            rst_sent = 1'b1;
        end
    endtask

    task automatic step();
        @(negedge prog_clk);
        start      = start_pend || (spam && last_busy);
        prog_reset = rst_pend;
        rst_pend   = 1'b0;
        if (gap_left > 0) begin
            s_valid = 1'b0;
            gap_left--;
        end else begin
            s_valid = (in_idx < NW);
            s_data  = (in_idx < NW) ? words[in_idx] : 8'h00;
        end
        m_ready = !(bp_wait || bp_left > 0);
        if (bp_left > 0) bp_left--;
        #1;
        cyc++;
        if (!prog_reset) sample();
    endtask

    task automatic run_pass(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                            input bit g, input bit bp, input bit sp, input bit rm);
        logic [CHAIN_LEN-1:0] nb;
        logic [7:0] rb;
        logic [7:0] w;
        words[0] = w0;
        words[1] = w1;
        words[2] = w2;
        exp_head_q.delete();
        exp_rb_q.delete();
        for (int k = 0; k < CHAIN_LEN; k++) begin
            w = words[k / WORD_W];
            nb[k] = w[k % WORD_W];
            exp_head_q.push_back(nb[k]);
            exp_chain[CHAIN_LEN - 1 - k] = nb[k];
        end
        // Readback of a pass is the chain as it stood before the pass, first-out bit first.
        for (int j = 0; j < NW; j++) begin
            rb = '0;
            for (int i = 0; i < WORD_W; i++)
                if (j * WORD_W + i < CHAIN_LEN) rb[i] = chain[CHAIN_LEN - 1 - (j * WORD_W + i)];
            exp_rb_q.push_back({(j == NW - 1), rb});
            got_rb[j] = 8'hEE;
        end
        got_last   = '0;
        got_head   = '0;
        in_idx     = 0;
        gaps_on    = g;
        gap_left   = g ? $urandom_range(0, 5) : 0;
        shift_cnt  = 0;
        consumed   = 0;
        done_cnt   = 0;
        rb_cnt     = 0;
        bp_shifts  = 0;
        bp_wait    = bp;
        bp_left    = 0;
        spam       = sp;
        rst_mode   = rm;
        rst_sent   = 1'b0;
        hold_valid = 1'b0;
        start_pend = 1'b1;
        first_acc_cyc   = -100;
        first_shift_cyc = -200;
        for (int c = 0; c < 400; c++) begin
            step();
            if (done_cnt > 0) break;
            if (rst_mode && prog_reset) break;
        end
        spam = 1'b0;
        if (rm) begin
            chk("shifts_before_reset", 32'(shift_cnt), 32'd9);
            step();
            check_idle("after_mid_reset");
            rst_mode = 1'b0;
            in_idx   = NW;
            exp_head_q.delete();
            exp_rb_q.delete();
        end else begin
            chk("pass_done", 32'(done_cnt), 32'd1);
            chk("shift_cycles", 32'(shift_cnt), CHAIN_LEN);
            chk("words_consumed", 32'(consumed), 32'(NW));
            chk("readback_words", 32'(rb_cnt), 32'(NW));
            chk("first_shift_latency", 32'(first_shift_cyc - first_acc_cyc), 32'd1);
            chk("final_chain", 32'(chain), 32'(exp_chain));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        prog_reset = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        cyc = 0;
        in_idx = NW;
        gap_left = 0;
        bp_left = 0;
        bp_wait = 1'b0;
        spam = 1'b0;
        rst_mode = 1'b0;
        rst_sent = 1'b0;
        start_pend = 1'b0;
        hold_valid = 1'b0;
        last_busy = 1'b0;
        rst_pend = 1'b1;
        step();
        rst_pend = 1'b1;
        step();
        step();
        check_idle("reset");

        // Nominal pass from an all-zero chain.
        run_pass(8'hA5, 8'h3C, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_head_seq", 32'(got_head), 32'h000F3CA5);
        chk("lit_rb0", 32'(got_rb[0]), 32'h00);
        chk("lit_rb1", 32'(got_rb[1]), 32'h00);
        chk("lit_rb2", 32'(got_rb[2]), 32'h00);
        chk("lit_last_flags", 32'(got_last), 32'b100);

        // Immediate rerun returns the first configuration.
        run_pass(8'hFF, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_rb_pass2_0", 32'(got_rb[0]), 32'hA5);
        chk("lit_rb_pass2_1", 32'(got_rb[1]), 32'h3C);
        chk("lit_rb_pass2_2", 32'(got_rb[2]), 32'h0F);

        run_pass(8'h5A, 8'hC3, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_rb_gaps_0", 32'(got_rb[0]), 32'hFF);
        chk("lit_rb_gaps_2", 32'(got_rb[2]), 32'h0F);

        // Backpressure: only the bits that fit in the accumulator may shift.
        run_pass(8'h12, 8'h34, 8'h56, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("bp_shifts_while_pending", 32'(bp_shifts), 32'(WORD_W - 1));

        run_pass(8'h9A, 8'hBC, 8'hDE, 1'b0, 1'b0, 1'b0, 1'b1);
        run_pass(8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);

        run_pass(8'h44, 8'h55, 8'h66, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step();
        chk("no_restart_busy", 32'(busy), 32'd0);
        chk("single_done_with_start_spam", 32'(done_cnt), 32'd1);
        chk("spam_words_consumed", 32'(consumed), 32'(NW));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
